// File: rtl/ysyx_23060236_ifu_pcgen.sv
// rtl/ysyx_23060236_ifu_pcgen.sv - fetch-side PC generator and instruction-fetch controller
//
// Holds the fetch PC. It issues one instruction read at a time on an AXI4-Lite-style
// read channel and hands {inst, pc, predicted next pc, err} to decode. It also absorbs
// EXU mispredict redirects, discarding any read still in flight.
//
// Build option: YSYX_IFU_BTB_EN
//   defined   - next pc is taken from the BTB lookup of the current pc
//   undefined - next pc is pc+4 and the BTB lookup address is tied to 0
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   btb_araddr/rdata    BTB lookup address (the pc) and its combinational prediction
//   ifu_ar*             read address channel (arvalid/araddr out, arready in)
//   ifu_r*              read data channel (rvalid/rdata/rresp in, rready out)
//   out_valid/ready     handshake to decode
//   out_inst/pc/pnpc    fetched word, its pc and predicted next pc
//   out_err             read response was not OKAY
//   redirect_valid/pc   one-cycle EXU mispredict redirect

module ysyx_23060236_ifu_pcgen #(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                clock,
    input  logic                reset,

    output logic [DATA_LEN-1:0] btb_araddr,
    input  logic [DATA_LEN-1:0] btb_rdata,

    output logic                ifu_arvalid,
    output logic [DATA_LEN-1:0] ifu_araddr,
    input  logic                ifu_arready,

    input  logic                ifu_rvalid,
    input  logic [DATA_LEN-1:0] ifu_rdata,
    input  logic [1:0]          ifu_rresp,
    output logic                ifu_rready,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_inst,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [DATA_LEN-1:0] out_pnpc,
    output logic                out_err,

    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_LEN-1:0] r_pc;
    logic [DATA_LEN-1:0] r_pnpc;
    logic [DATA_LEN-1:0] r_inst;
    logic                r_err;
    // r_kill marks the outstanding read as stale; r_rpc is where to resume once it drains
    logic                r_kill;
    logic [DATA_LEN-1:0] r_rpc;

    logic [DATA_LEN-1:0] w_pnpc_pred;

`ifdef YSYX_IFU_BTB_EN
    assign w_pnpc_pred = btb_rdata;
    assign btb_araddr  = r_pc;
`else
    logic w_unused_btb;
    assign w_pnpc_pred  = r_pc + DATA_LEN'(4);
    assign btb_araddr   = '0;
    assign w_unused_btb = ^btb_rdata;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ifu_arvalid = 1'b0;
        ifu_araddr  = '0;
        ifu_rready  = 1'b0;
        out_valid   = 1'b0;
        out_inst    = '0;
        out_pc      = '0;
        out_pnpc    = '0;
        out_err     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                ifu_arvalid = 1'b1;
                ifu_araddr  = r_pc;
                // A redirect here does not withdraw the request; the read is drained in WAIT
                if (ifu_arready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                ifu_rready = 1'b1;
                if (ifu_rvalid) begin
                    w_state_nxt = (redirect_valid || r_kill) ? S_REQ : S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_inst  = r_inst;
                out_pc    = r_pc;
                out_pnpc  = r_pnpc;
                out_err   = r_err;
                // A transfer coinciding with a redirect is void; EXU ignores it
                if (redirect_valid || out_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pc, prediction, captured read data and kill bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_pnpc <= '0;
            r_inst <= '0;
            r_err  <= 1'b0;
            r_kill <= 1'b0;
            r_rpc  <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_kill <= 1'b1;
                        r_rpc  <= redirect_pc;
                    end
                    if (ifu_arready) begin
                        r_pnpc <= w_pnpc_pred;
                    end
                end
                S_WAIT: begin
                    if (ifu_rvalid) begin
                        if (redirect_valid) begin
                            r_pc   <= redirect_pc;
                            r_kill <= 1'b0;
                        end else if (r_kill) begin
                            r_pc   <= r_rpc;
                            r_kill <= 1'b0;
                        end else begin
                            r_inst <= ifu_rdata;
                            r_err  <= |ifu_rresp;
                        end
                    end else if (redirect_valid) begin
                        // Newest redirect overwrites any earlier pending one
                        r_kill <= 1'b1;
                        r_rpc  <= redirect_pc;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (out_ready) begin
                        r_pc <= r_pnpc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_ifu_pcgen.sv
// tb/tb_ysyx_23060236_ifu_pcgen.sv - self-checking bench for ysyx_23060236_ifu_pcgen

module tb_ysyx_23060236_ifu_pcgen;

    localparam logic [31:0] RESET_PC    = 32'h3000_0000;
    localparam logic [31:0] BTB_HIT_PC  = 32'h3000_0004;
    localparam logic [31:0] BTB_HIT_TGT = 32'h3000_0100;

    logic        clock;
    logic        reset;
    logic [31:0] btb_araddr;
    logic [31:0] btb_rdata;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_23060236_ifu_pcgen #(
        .DATA_LEN (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .btb_araddr     (btb_araddr),
        .btb_rdata      (btb_rdata),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_araddr     (ifu_araddr),
        .ifu_arready    (ifu_arready),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rdata      (ifu_rdata),
        .ifu_rresp      (ifu_rresp),
        .ifu_rready     (ifu_rready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pnpc       (out_pnpc),
        .out_err        (out_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Environment: instruction memory contents and BTB predictor
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] btb_fn(input logic [31:0] a);
        if (a == BTB_HIT_PC) return BTB_HIT_TGT;
        if (a[6:2] == 5'h1f) return a + 32'h40;
        return a + 32'd4;
    endfunction

    assign btb_rdata = btb_fn(btb_araddr);

    // Reference: the pc decode should receive after an accepted instruction
    function automatic logic [31:0] pred(input logic [31:0] a);
`ifdef YSYX_IFU_BTB_EN
        return btb_fn(a);
`else
        return a + 32'd4;
`endif
    endfunction

    // Stimulus knobs (written by the main sequence, read by the environment)
    int          cfg_ar_prob    = 100;
    int          cfg_or_prob    = 100;
    int          cfg_lat        = 0;
    bit          cfg_lat_rand   = 0;
    logic [1:0]  cfg_resp       = 2'b00;
    bit          cfg_resp_rand  = 0;
    int          cfg_redir_prob = 0;
    bit          req_redir      = 0;
    logic [31:0] req_redir_pc   = '0;

    // Environment state and transaction logs
    bit          pend;
    logic [31:0] pend_addr;
    int          lat_cnt;
    bit          last_rerr;
    logic [31:0] exp_pc;
    int          cycle   = 0;
    int          n_out   = 0;
    int          out_seen = 0;
    bit          prev_ar_stall, prev_out_stall;
    logic [31:0] prev_araddr, prev_inst, prev_pc, prev_pnpc;
    logic        prev_err;
    logic [31:0] ar_log[$];
    int          ar_cyc[$];
    logic [31:0] out_pc_log[$], out_inst_log[$], out_pnpc_log[$];
    int          out_cyc[$];

    task automatic clear_logs();
        ar_log.delete(); ar_cyc.delete();
        out_pc_log.delete(); out_inst_log.delete(); out_pnpc_log.delete(); out_cyc.delete();
        out_seen = 0;
    endtask

    initial begin : env
        bit busy;
        ifu_arready = 0; ifu_rvalid = 0; ifu_rdata = 0; ifu_rresp = 0;
        out_ready = 0; redirect_valid = 0; redirect_pc = 0;
        pend = 0; exp_pc = RESET_PC; lat_cnt = 0; last_rerr = 0;
        prev_ar_stall = 0; prev_out_stall = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                ifu_arready = 0; ifu_rvalid = 0; ifu_rdata = 0; ifu_rresp = 0;
                out_ready = 0; redirect_valid = 0; redirect_pc = 0;
                pend = 0; exp_pc = RESET_PC; prev_ar_stall = 0; prev_out_stall = 0;
            end else begin
                busy        = ifu_arvalid | ifu_rready | out_valid;
                ifu_arready = ($urandom_range(0, 99) < cfg_ar_prob);
                out_ready   = ($urandom_range(0, 99) < cfg_or_prob);
                ifu_rvalid  = 0;
                if (pend) begin
                    if (lat_cnt == 0) begin
                        ifu_rvalid = 1;
                        ifu_rdata  = mem_fn(pend_addr);
                        if (cfg_resp_rand)
                            ifu_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                        else
                            ifu_rresp = cfg_resp;
                    end else begin
                        lat_cnt--;
                    end
                end
                redirect_valid = 0;
                if (busy && req_redir) begin
                    redirect_valid = 1;
                    redirect_pc    = req_redir_pc;
                    req_redir      = 0;
                end else if (busy && ($urandom_range(0, 99) < cfg_redir_prob)) begin
                    redirect_valid = 1;
                    redirect_pc    = 32'h3000_0000 | ($urandom & 32'h000f_fffc);
                end
            end

            @(negedge clock);
            cycle++;
            if (reset) begin
                if (prev_ar_stall) begin
                    check("ar_hold_valid", 32'(ifu_arvalid), 1);
                    check("ar_hold_addr", ifu_araddr, prev_araddr);
                end
                if (prev_out_stall) begin
                    check("out_hold_valid", 32'(out_valid), 1);
                    check("out_hold_pc", out_pc, prev_pc);
                    check("out_hold_inst", out_inst, prev_inst);
                    check("out_hold_pnpc", out_pnpc, prev_pnpc);
                    check("out_hold_err", 32'(out_err), 32'(prev_err));
                end
`ifdef YSYX_IFU_BTB_EN
                if (ifu_arvalid) check("btb_addr", btb_araddr, ifu_araddr);
`else
                check("btb_addr_tied", btb_araddr, 0);
`endif
                if (ifu_rvalid && ifu_rready) begin
                    pend      = 0;
                    last_rerr = (ifu_rresp != 2'b00);
                end
                if (ifu_arvalid && ifu_arready) begin
                    check("one_outstanding", 32'(pend), 0);
                    ar_log.push_back(ifu_araddr);
                    ar_cyc.push_back(cycle);
                    pend      = 1;
                    pend_addr = ifu_araddr;
                    lat_cnt   = cfg_lat_rand ? int'($urandom_range(0, 3)) : cfg_lat;
                end
                if (out_valid) out_seen++;
                if (redirect_valid) begin
                    exp_pc = redirect_pc;
                end else if (out_valid && out_ready) begin
                    check("out_pc", out_pc, exp_pc);
                    check("out_inst", out_inst, mem_fn(exp_pc));
                    check("out_pnpc", out_pnpc, pred(exp_pc));
                    check("out_err", 32'(out_err), 32'(last_rerr));
                    out_pc_log.push_back(out_pc);
                    out_inst_log.push_back(out_inst);
                    out_pnpc_log.push_back(out_pnpc);
                    out_cyc.push_back(cycle);
                    n_out++;
                    exp_pc = pred(exp_pc);
                end
                prev_ar_stall  = ifu_arvalid && !ifu_arready;
                prev_araddr    = ifu_araddr;
                prev_out_stall = out_valid && !out_ready && !redirect_valid;
                prev_pc = out_pc; prev_inst = out_inst; prev_pnpc = out_pnpc; prev_err = out_err;
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
        #2;
    endtask

    // kind: 0 arvalid, 1 rready, 2 out_valid, otherwise at least n AR handshakes logged
    task automatic wait_for(input int kind, input int n, input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            case (kind)
                0:       ok = ifu_arvalid;
                1:       ok = ifu_rready;
                2:       ok = out_valid;
                default: ok = (ar_log.size() >= n);
            endcase
            if (ok) break;
            cyc();
        end
        check(tag, 32'(ok), 1);
    endtask

    initial begin : main
        logic [31:0] a, snap_pc, snap_inst, snap_pnpc;
        reset = 0;
        repeat (3) cyc();
        check("rst_arvalid", 32'(ifu_arvalid), 0);
        check("rst_rready", 32'(ifu_rready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_araddr", ifu_araddr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pnpc", out_pnpc, 0);
        check("rst_out_err", 32'(out_err), 0);

        // First fetch and BTB hit at RESET_PC+4
        clear_logs();
        reset = 1;
        repeat (12) cyc();
        check("t1_ar0", ar_log[0], 32'h3000_0000);
        check("t1_out_pc", out_pc_log[0], 32'h3000_0000);
        check("t1_out_inst", out_inst_log[0], 32'h0000_0013);
        check("t1_out_pnpc", out_pnpc_log[0], 32'h3000_0004);
        check("t1_ar1", ar_log[1], 32'h3000_0004);
        check("t1_lat_out", 32'(out_cyc[0] - ar_cyc[0]), 2);
        check("t1_lat_ar", 32'(ar_cyc[1] - ar_cyc[0]), 3);
`ifdef YSYX_IFU_BTB_EN
        check("t2_pnpc", out_pnpc_log[1], 32'h3000_0100);
        check("t2_ar", ar_log[2], 32'h3000_0100);
`else
        check("t2_pnpc", out_pnpc_log[1], 32'h3000_0008);
        check("t2_ar", ar_log[2], 32'h3000_0008);
`endif

        // Redirect in WAIT with delayed rvalid
        cfg_lat = 3;
        repeat (4) cyc();
        wait_for(1, 0, "t3_wait_state");
        clear_logs();
        req_redir_pc = 32'h3000_0200;
        req_redir    = 1;
        wait_for(3, 1, "t3_next_ar");
        check("t3_ar", ar_log[0], 32'h3000_0200);
        check("t3_no_out", 32'(out_seen), 0);

        // Redirect during a stalled AR
        cfg_lat     = 0;
        cfg_ar_prob = 0;
        cyc();
        wait_for(0, 0, "t4_arvalid");
        a = ifu_araddr;
        clear_logs();
        req_redir_pc = 32'h3000_0300;
        req_redir    = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_ar_stable", ifu_araddr, a);
        end
        cfg_ar_prob = 100;
        wait_for(3, 2, "t4_two_ar");
        check("t4_ar_stale", ar_log[0], a);
        check("t4_ar_new", ar_log[1], 32'h3000_0300);
        check("t4_no_out", 32'(out_seen), 0);

        // Backpressure with an error response
        cfg_resp = 2'b10;
        repeat (4) cyc();
        cfg_or_prob = 0;
        cyc();
        wait_for(2, 0, "t5_out_valid");
        snap_pc = out_pc; snap_inst = out_inst; snap_pnpc = out_pnpc;
        check("t5_err", 32'(out_err), 1);
        check("t5_pnpc", snap_pnpc, pred(snap_pc));
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t5_valid_held", 32'(out_valid), 1);
            check("t5_no_ar", 32'(ifu_arvalid), 0);
            check("t5_inst_held", out_inst, snap_inst);
        end
        clear_logs();
        cfg_resp    = 2'b00;
        cfg_or_prob = 100;
        wait_for(3, 1, "t5_next_ar");
        check("t5_ar", ar_log[0], pred(snap_pc));

        // Redirect coincident with out_ready
        cfg_or_prob = 0;
        cyc();
        wait_for(2, 0, "t6_out_valid");
        clear_logs();
        req_redir_pc = 32'h3000_0400;
        req_redir    = 1;
        cfg_or_prob  = 100;
        wait_for(3, 1, "t6_next_ar");
        check("t6_ar", ar_log[0], 32'h3000_0400);
        check("t6_void", 32'(out_pc_log.size()), 0);

        // Randomized traffic against the reference model
        cfg_ar_prob    = 70;
        cfg_or_prob    = 70;
        cfg_lat_rand   = 1;
        cfg_resp_rand  = 1;
        cfg_redir_prob = 6;
        n_out = 0;
        repeat (3000) cyc();
        check("rand_progress", 32'(n_out > 100), 1);

        // Asynchronous reset mid-transaction
        cfg_redir_prob = 0;
        cyc();
        reset = 0;
        #1;
        check("arst_arvalid", 32'(ifu_arvalid), 0);
        check("arst_rready", 32'(ifu_rready), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_araddr", ifu_araddr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
